// File: rtl/phase2speed_mc.sv
// Multi-channel phase-to-speed converter: per-channel block average, gain, saturate.
// Define PHASE2SPEED_MC_ROUND_EN for round-half-away-from-zero instead of truncation.
module phase2speed_mc #(
  parameter int unsigned NCH     = 2,
  parameter int unsigned CH_W    = 1,
  parameter int unsigned N       = 11,
  parameter int unsigned PHASE_W = 19,
  parameter int unsigned SPEED_W = 16,
  parameter int unsigned SCALE_W = 18,
  parameter int          SCALE   = 65536,
  parameter int unsigned SHIFT   = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      sample,
  input  logic signed [PHASE_W-1:0] phase,
  input  logic        [CH_W-1:0]    chan,
  output logic signed [SPEED_W-1:0] speed,
  output logic        [CH_W-1:0]    speed_ch,
  output logic                      ready,
  output logic                      sat
);

  localparam int unsigned ACC_W  = PHASE_W + N;
  localparam int unsigned PROD_W = ACC_W + SCALE_W;
  localparam int unsigned EXT_W  = PROD_W + 1;
  localparam int unsigned SH     = N + SHIFT;

  localparam logic signed [SCALE_W-1:0] ScaleC = SCALE_W'(SCALE);
  localparam logic signed [EXT_W-1:0]   SatMax = EXT_W'({1'b0, {(SPEED_W-1){1'b1}}});
  localparam logic signed [EXT_W-1:0]   SatMin = ~SatMax;
  localparam logic signed [SPEED_W-1:0] SpdMax = {1'b0, {(SPEED_W-1){1'b1}}};
  localparam logic signed [SPEED_W-1:0] SpdMin = {1'b1, {(SPEED_W-1){1'b0}}};
`ifdef PHASE2SPEED_MC_ROUND_EN
  localparam logic signed [EXT_W-1:0]   RndHalf   = EXT_W'(1) <<< (SH - 1);
  localparam logic signed [EXT_W-1:0]   RndHalfM1 = RndHalf - EXT_W'(1);
`endif

  // Per-channel block state
  logic signed [ACC_W-1:0] acc_q [NCH];
  logic signed [ACC_W-1:0] acc_d [NCH];
  logic        [N-1:0]     cnt_q [NCH];
  logic        [N-1:0]     cnt_d [NCH];

  // Stage 0 -> 1
  logic signed [ACC_W-1:0] sum_q, sum_d;
  logic        [CH_W-1:0]  ch0_q, ch0_d;
  logic                    v0_q, v0_d;

  // Stage 1 -> 2
  logic signed [PROD_W-1:0] prod_q, prod_d;
  logic        [CH_W-1:0]   ch1_q, ch1_d;
  logic                     v1_q, v1_d;

  // Output registers
  logic signed [SPEED_W-1:0] speed_q, speed_d;
  logic        [CH_W-1:0]    speed_ch_q, speed_ch_d;
  logic                      ready_q, ready_d;
  logic                      sat_q, sat_d;

  logic signed [EXT_W-1:0] ext;
  logic signed [EXT_W-1:0] q;

  // Stage 0: accumulate; the last sample of a block goes straight into sum_d.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    sum_d = sum_q;
    ch0_d = ch0_q;
    v0_d  = 1'b0;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (sample && (32'(chan) == c)) begin
        if (cnt_q[c] != '1) begin
          acc_d[c] = acc_q[c] + ACC_W'(phase);
          cnt_d[c] = cnt_q[c] + N'(1);
        end else begin
          sum_d    = acc_q[c] + ACC_W'(phase);
          ch0_d    = chan;
          v0_d     = 1'b1;
          acc_d[c] = '0;
          cnt_d[c] = '0;
        end
      end
    end
  end

  // Stage 1: full-width signed gain multiply
  always_comb begin
    prod_d = PROD_W'(sum_q) * PROD_W'(ScaleC);
    ch1_d  = ch0_q;
    v1_d   = v0_q;
  end

  // Stage 2: divide by block length plus SHIFT, then saturate
  always_comb begin
    ext = EXT_W'(prod_q);
`ifdef PHASE2SPEED_MC_ROUND_EN
    ext = ext + (prod_q[PROD_W-1] ? RndHalfM1 : RndHalf);
`endif
    q          = ext >>> SH;
    speed_d    = speed_q;
    speed_ch_d = speed_ch_q;
    sat_d      = sat_q;
    ready_d    = v1_q;
    if (v1_q) begin
      speed_ch_d = ch1_q;
      if (q > SatMax) begin
        speed_d = SpdMax;
        sat_d   = 1'b1;
      end else if (q < SatMin) begin
        speed_d = SpdMin;
        sat_d   = 1'b1;
      end else begin
        speed_d = q[SPEED_W-1:0];
        sat_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        acc_q[c] <= '0;
        cnt_q[c] <= '0;
      end
      sum_q      <= '0;
      ch0_q      <= '0;
      v0_q       <= 1'b0;
      prod_q     <= '0;
      ch1_q      <= '0;
      v1_q       <= 1'b0;
      speed_q    <= '0;
      speed_ch_q <= '0;
      ready_q    <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      ch0_q      <= ch0_d;
      v0_q       <= v0_d;
      prod_q     <= prod_d;
      ch1_q      <= ch1_d;
      v1_q       <= v1_d;
      speed_q    <= speed_d;
      speed_ch_q <= speed_ch_d;
      ready_q    <= ready_d;
      sat_q      <= sat_d;
    end
  end

  assign speed    = speed_q;
  assign speed_ch = speed_ch_q;
  assign ready    = ready_q;
  assign sat      = sat_q;

endmodule
